match_window_counter: RTL and testbench

- Downstream consumer of the serial 1101 Mealy detector's one-cycle match pulse `o`.
- Counts match pulses over a programmable window of clock cycles and reports the total once per window, with a single-cycle valid strobe.
- Raises an alarm when the count meets a threshold; flags counter saturation.
- Sits between the detector and the status/register logic.

---
 rtl/match_window_counter.sv | 169 ++++++++++++++++
 tb/tb_match_window_counter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/match_window_counter.sv
// ---------------------------------------------------------------------------
// match_window_counter
//
// Counts one-cycle match pulses from the serial 1101 detector over a
// programmable window of clock cycles. At the end of each window it reports
// the total with a single-cycle valid strobe. It also raises an alarm when
// the total meets the latched threshold, and keeps a sticky flag if the
// counter ever saturates.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous, active-low reset
//   clear        synchronous clear, highest priority below n_rst
//   enable       start request, sampled only in IDLE and REPORT
//   match        detector match pulse, one count per high COUNT cycle
//   win_len      window length in cycles (0 = invalid, request ignored)
//   threshold    alarm threshold, latched at window start
//   count_out    final count of the last completed window
//   count_valid  one-cycle strobe, count_out updated this cycle
//   alarm        last reported count >= latched threshold
//   overflow     sticky, an increment was attempted at max count
//   busy         high in COUNT and REPORT
// ---------------------------------------------------------------------------
module match_window_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             match,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             alarm,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic             count_valid_q, count_valid_d;
  logic             alarm_q, alarm_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;

  logic             start_ok;
  logic             cnt_max;
  logic [CNT_W-1:0] cnt_inc;

  // A start request only counts when the requested window is non-empty.
  assign start_ok = enable && (win_len != '0);
  assign cnt_max  = (cnt_q == {CNT_W{1'b1}});

  // The counter value after this cycle's match, held at the maximum.
  // It feeds the report directly, so a match in the last window cycle is
  // included in count_out and in the alarm compare.
  assign cnt_inc  = (match && !cnt_max) ? (cnt_q + CNT_W'(1)) : cnt_q;

  // Next-state logic: clear overrides everything, including a simultaneous
  // enable. Outputs are computed here and registered below, so all of them
  // change together on the clock edge that enters the new state.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cnt_d         = cnt_q;
    thr_d         = thr_q;
    count_out_d   = count_out_q;
    count_valid_d = 1'b0;
    alarm_d       = alarm_q;
    overflow_d    = overflow_q;

    if (clear) begin
      state_d     = IDLE;
      timer_d     = '0;
      cnt_d       = '0;
      count_out_d = '0;
      alarm_d     = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            timer_d = win_len;
            thr_d   = threshold;
            cnt_d   = '0;
            state_d = COUNT;
          end
        end

        COUNT: begin
          cnt_d   = cnt_inc;
          timer_d = timer_q - WIN_W'(1);
          if (match && cnt_max) begin
            overflow_d = 1'b1;
          end
          // timer==1 marks the last of the win_len counting cycles.
          if (timer_q == WIN_W'(1)) begin
            state_d       = REPORT;
            count_out_d   = cnt_inc;
            count_valid_d = 1'b1;
            alarm_d       = (cnt_inc >= thr_q);
          end
        end

        REPORT: begin
          // Back-to-back windows are separated only by this report cycle.
          if (start_ok) begin
            timer_d = win_len;
            thr_d   = threshold;
            cnt_d   = '0;
            state_d = COUNT;
          end else begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign busy_d = (state_d != IDLE);

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      cnt_q         <= '0;
      thr_q         <= '0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      alarm_q       <= 1'b0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cnt_q         <= cnt_d;
      thr_q         <= thr_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      alarm_q       <= alarm_d;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
    end
  end

  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign alarm       = alarm_q;
  assign overflow    = overflow_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_match_window_counter.sv
// ---------------------------------------------------------------------------
// tb_match_window_counter
//
// Directed bench for match_window_counter. Each expected report
// (count, alarm, overflow) is queued when its window is started. The
// monitor pops and compares an entry whenever the DUT strobes count_valid.
// Inline checks cover busy, holding behaviour, clear and reset.
// ---------------------------------------------------------------------------
module tb_match_window_counter;

  logic        clk;
  logic        n_rst;
  logic        clear;
  logic        enable;
  logic        match;
  logic [15:0] win_len;
  logic [7:0]  threshold;
  logic [7:0]  count_out;
  logic        count_valid;
  logic        alarm;
  logic        overflow;
  logic        busy;

  typedef struct packed {
    logic [7:0] cnt;
    logic       alarm;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  int pass_count  = 0;
  int check_count = 0;

  match_window_counter #(.CNT_W(8), .WIN_W(16)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (clear),
    .enable      (enable),
    .match       (match),
    .win_len     (win_len),
    .threshold   (threshold),
    .count_out   (count_out),
    .count_valid (count_valid),
    .alarm       (alarm),
    .overflow    (overflow),
    .busy        (busy)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, counts a pass, or reports the mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Drives one cycle of inputs, then returns 1 time unit after the edge
  // that sampled them, so registered outputs are stable for checking.
  task automatic applyStimulus(input logic en, input logic m, input logic [15:0] wl,
                               input logic [7:0] th, input logic clr);
    enable    = en;
    match     = m;
    win_len   = wl;
    threshold = th;
    clear     = clr;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every valid strobe must match the oldest queued
  // expectation. A strobe with nothing queued is a failure.
  always @(negedge clk) begin
    if (n_rst && count_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sb_count", {24'd0, count_out}, {24'd0, e.cnt});
        checkOutput("sb_alarm", {31'd0, alarm}, {31'd0, e.alarm});
        checkOutput("sb_overflow", {31'd0, overflow}, {31'd0, e.ovf});
      end
    end
  end

  initial begin
    n_rst     = 1'b0;
    clear     = 1'b0;
    enable    = 1'b0;
    match     = 1'b0;
    win_len   = 16'd0;
    threshold = 8'd0;

    // Reset state, then 20 idle cycles with enable low.
    #12;
    checkOutput("reset_outputs", {27'd0, count_out, count_valid, alarm, overflow, busy}, 32'd0);
    #10;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 16'd10, 8'd3, 1'b0);
      checkOutput("idle_after_reset", {27'd0, count_out, count_valid, alarm, overflow, busy}, 32'd0);
    end

    // Basic window: 10 cycles, threshold 3, matches in cycles 1, 5 and 10.
    sb.push_back('{cnt: 8'd3, alarm: 1'b1, ovf: 1'b0});
    applyStimulus(1'b1, 1'b0, 16'd10, 8'd3, 1'b0);
    checkOutput("basic_busy_start", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, (i == 1) || (i == 5) || (i == 10), 16'd10, 8'd3, 1'b0);
      if (i == 5) checkOutput("basic_busy_mid", {31'd0, busy}, 32'd1);
    end
    checkOutput("basic_valid", {31'd0, count_valid}, 32'd1);
    checkOutput("basic_count", {24'd0, count_out}, 32'd3);
    checkOutput("basic_alarm_eq_thr", {31'd0, alarm}, 32'd1);
    applyStimulus(1'b0, 1'b0, 16'd10, 8'd3, 1'b0);
    checkOutput("basic_valid_one_cycle", {31'd0, count_valid}, 32'd0);
    checkOutput("basic_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("basic_count_hold", {24'd0, count_out}, 32'd3);

    // Matches in IDLE and a zero-length request are both ignored.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 16'd6, 8'd5, 1'b0);
      checkOutput("idle_match_busy", {31'd0, busy}, 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 16'd0, 8'd5, 1'b0);
    checkOutput("zero_len_busy", {31'd0, busy}, 32'd0);
    applyStimulus(1'b0, 1'b0, 16'd0, 8'd5, 1'b0);
    checkOutput("zero_len_no_valid", {31'd0, count_valid}, 32'd0);
    checkOutput("idle_count_hold", {24'd0, count_out}, 32'd3);

    // Window of 6 with two matches and threshold 5: no alarm.
    sb.push_back('{cnt: 8'd2, alarm: 1'b0, ovf: 1'b0});
    applyStimulus(1'b1, 1'b0, 16'd6, 8'd5, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b0, (i == 2) || (i == 4), 16'd6, 8'd5, 1'b0);
    end
    checkOutput("two_count", {24'd0, count_out}, 32'd2);
    checkOutput("two_alarm", {31'd0, alarm}, 32'd0);

    // A match in the REPORT cycle must not leak into the next window.
    // The back-to-back 3-cycle window with threshold 0 reports 0 with alarm.
    sb.push_back('{cnt: 8'd0, alarm: 1'b1, ovf: 1'b0});
    applyStimulus(1'b1, 1'b1, 16'd3, 8'd0, 1'b0);
    checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b0, 16'd3, 8'd0, 1'b0);
    end
    checkOutput("report_match_ignored", {24'd0, count_out}, 32'd0);
    checkOutput("thr_zero_alarm", {31'd0, alarm}, 32'd1);
    applyStimulus(1'b0, 1'b0, 16'd3, 8'd0, 1'b0);

    // Saturation: 300 cycles of matches.
    sb.push_back('{cnt: 8'd255, alarm: 1'b1, ovf: 1'b1});
    applyStimulus(1'b1, 1'b0, 16'd300, 8'd200, 1'b0);
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(1'b0, 1'b1, 16'd300, 8'd200, 1'b0);
    end
    checkOutput("sat_count", {24'd0, count_out}, 32'd255);
    checkOutput("sat_overflow", {31'd0, overflow}, 32'd1);
    applyStimulus(1'b0, 1'b0, 16'd300, 8'd200, 1'b0);

    // A new window does not clear the sticky overflow.
    sb.push_back('{cnt: 8'd1, alarm: 1'b0, ovf: 1'b1});
    applyStimulus(1'b1, 1'b0, 16'd5, 8'd2, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, (i == 3), 16'd5, 8'd2, 1'b0);
    end
    checkOutput("after_sat_count", {24'd0, count_out}, 32'd1);
    checkOutput("overflow_sticky", {31'd0, overflow}, 32'd1);
    applyStimulus(1'b0, 1'b0, 16'd5, 8'd2, 1'b0);

    // Continuous mode: enable held, 4-cycle windows, match every cycle.
    sb.push_back('{cnt: 8'd4, alarm: 1'b1, ovf: 1'b1});
    applyStimulus(1'b1, 1'b1, 16'd4, 8'd4, 1'b0);
    for (int w = 0; w < 3; w++) begin
      for (int j = 1; j <= 4; j++) begin
        applyStimulus(1'b1, 1'b1, 16'd4, 8'd4, 1'b0);
        checkOutput("cont_busy", {31'd0, busy}, 32'd1);
        checkOutput("cont_valid", {31'd0, count_valid}, {31'd0, (j == 4)});
      end
      if (w < 2) begin
        sb.push_back('{cnt: 8'd4, alarm: 1'b1, ovf: 1'b1});
        applyStimulus(1'b1, 1'b1, 16'd4, 8'd4, 1'b0);
        checkOutput("cont_busy_gap", {31'd0, busy}, 32'd1);
        checkOutput("cont_valid_gap", {31'd0, count_valid}, 32'd0);
      end else begin
        applyStimulus(1'b0, 1'b0, 16'd4, 8'd4, 1'b0);
      end
    end
    checkOutput("cont_stop_busy", {31'd0, busy}, 32'd0);

    // Clear in window cycle 6 of 10 abandons the window without a report.
    applyStimulus(1'b1, 1'b0, 16'd10, 8'd0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b1, 16'd10, 8'd0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 16'd10, 8'd0, 1'b1);
    checkOutput("clear_outputs", {27'd0, count_out, count_valid, alarm, overflow, busy}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 16'd10, 8'd0, 1'b0);
      checkOutput("clear_no_report", {31'd0, count_valid}, 32'd0);
    end

    // Clear and enable together: clear wins, FSM stays idle.
    applyStimulus(1'b1, 1'b0, 16'd10, 8'd0, 1'b1);
    checkOutput("clear_beats_enable", {31'd0, busy}, 32'd0);

    // Load non-zero outputs, then assert n_rst mid-window.
    sb.push_back('{cnt: 8'd2, alarm: 1'b1, ovf: 1'b0});
    applyStimulus(1'b1, 1'b0, 16'd3, 8'd1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, (i != 2), 16'd3, 8'd1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 16'd3, 8'd1, 1'b0);
    checkOutput("pre_rst_count", {24'd0, count_out}, 32'd2);
    applyStimulus(1'b1, 1'b0, 16'd10, 8'd1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b1, 16'd10, 8'd1, 1'b0);
    end
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("async_rst_outputs", {27'd0, count_out, count_valid, alarm, overflow, busy}, 32'd0);
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 16'd10, 8'd1, 1'b0);
      checkOutput("post_rst_idle", {27'd0, count_out, count_valid, alarm, overflow, busy}, 32'd0);
    end

    // Every queued report must have been seen.
    checkOutput("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
